// File: rtl/sar_logic_param.sv
// sar_logic_param: successive-approximation register control logic.
// Ports: clk, rst (sync, active-high), start, cont, skip[3:0], Comp, CompN in;
//        Samp, B/BN[NBITS], busy, eoc, dout[NBITS], dout_valid, cmp_err out.
module sar_logic_param #(
  parameter int NBITS         = 10,
  parameter int SAMPLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cont,
  input  logic [3:0]       skip,
  input  logic             Comp,
  input  logic             CompN,
  output logic             Samp,
  output logic [NBITS-1:0] B,
  output logic [NBITS-1:0] BN,
  output logic             busy,
  output logic             eoc,
  output logic [NBITS-1:0] dout,
  output logic             dout_valid,
  output logic             cmp_err
);

  localparam int KW = $clog2(NBITS);
  localparam int SW = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
  localparam logic [NBITS-1:0] ONES = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SAMPLE,
    S_CONVERT,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [KW-1:0]    r_k;
  logic [KW-1:0]    r_skip;
  logic [SW-1:0]    r_scnt;
  logic [NBITS-1:0] r_b;
  logic [NBITS-1:0] r_bn;
  logic [NBITS-1:0] r_dout;
  logic             r_samp;
  logic             r_busy;
  logic             r_eoc;
  logic             r_dv;
  logic             r_err;

  logic [KW-1:0]    w_skip_c;
  logic [NBITS-1:0] w_b_res;

  // Skip counts at or beyond the word width leave only the MSB converted.
  always_comb begin
    w_skip_c = KW'(skip);
    if ({28'd0, skip} >= 32'(NBITS))
      w_skip_c = KW'(NBITS - 1);
  end

  // Word as it stands once the current bit takes the comparator decision.
  always_comb begin
    w_b_res      = r_b;
    w_b_res[r_k] = Comp;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_k     <= '0;
      r_skip  <= '0;
      r_scnt  <= '0;
      r_b     <= '0;
      r_bn    <= ONES;
      r_dout  <= '0;
      r_samp  <= 1'b0;
      r_busy  <= 1'b0;
      r_eoc   <= 1'b0;
      r_dv    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_eoc <= 1'b0;
      r_dv  <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_SAMPLE;
            r_skip  <= w_skip_c;
            r_err   <= 1'b0;
            r_samp  <= 1'b1;
            r_busy  <= 1'b1;
            r_b     <= '0;
            r_bn    <= ONES;
            r_scnt  <= '0;
          end
        end
        S_SAMPLE: begin
          if (r_scnt == SW'(SAMPLE_CYCLES - 1)) begin
            r_state         <= S_CONVERT;
            r_samp          <= 1'b0;
            r_b[NBITS-1]    <= 1'b1;
            r_bn[NBITS-1]   <= 1'b0;
            r_k             <= KW'(NBITS - 1);
          end else begin
            r_scnt <= r_scnt + 1'b1;
          end
        end
        S_CONVERT: begin
          r_b[r_k]  <= Comp;
          r_bn[r_k] <= CompN;
          // Both rails equal means the comparator is not trustworthy.
          if (Comp == CompN)
            r_err <= 1'b1;
          if (r_k > r_skip) begin
            r_b[r_k - 1'b1]  <= 1'b1;
            r_bn[r_k - 1'b1] <= 1'b0;
            r_k              <= r_k - 1'b1;
          end else begin
            r_state <= S_DONE;
            r_dout  <= w_b_res;
            r_eoc   <= 1'b1;
            r_dv    <= 1'b1;
          end
        end
        S_DONE: begin
          if (cont) begin
            r_state <= S_SAMPLE;
            r_skip  <= w_skip_c;
            r_samp  <= 1'b1;
            r_b     <= '0;
            r_bn    <= ONES;
            r_scnt  <= '0;
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_samp  <= 1'b0;
        end
      endcase
    end
  end

  assign Samp       = r_samp;
  assign B          = r_b;
  assign BN         = r_bn;
  assign busy       = r_busy;
  assign eoc        = r_eoc;
  assign dout       = r_dout;
  assign dout_valid = r_dv;
  assign cmp_err    = r_err;

endmodule
